// File: rtl/param_simd_lane_seq_if.sv
// param_simd_lane_seq_if: decoded-instruction handshake into the SIMD micro-op sequencer.
interface param_simd_lane_seq_if;
    logic       inst_val;
    logic       inst_rdy;
    logic [2:0] inst_op;
    logic       inst_use_imm;
    logic [4:0] inst_rs1;
    logic [4:0] inst_rs2;
    logic [4:0] inst_rd;
    modport master (output inst_val, inst_op, inst_use_imm, inst_rs1, inst_rs2, inst_rd, input inst_rdy);
    modport slave  (input inst_val, inst_op, inst_use_imm, inst_rs1, inst_rs2, inst_rd, output inst_rdy);
endinterface

// File: rtl/param_simd_lane_seq.sv
// param_simd_lane_seq: issues one subword micro-op per cycle for a decoded RV32 ALU/branch instruction.
module param_simd_lane_seq #(
    parameter int P_NBITS   = 4,
    parameter int C_N_OFF   = 8,
    parameter int C_OFFBITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    param_simd_lane_seq_if.slave   inst,
    input  logic                   stall_Rhl,
    output logic [4:0]             rega_addr_Rhl,
    output logic [4:0]             regb_addr_Rhl,
    output logic [C_OFFBITS-1:0]   a_subword_off_Rhl,
    output logic [C_OFFBITS-1:0]   b_subword_off_Rhl,
    output logic                   a_mux_sel_Xhl,
    output logic                   b_mux_sel_Xhl,
    output logic                   wb_en_Xhl,
    output logic [4:0]             wb_addr_Xhl,
    output logic [C_OFFBITS-1:0]   wb_subword_off_Xhl,
    output logic                   addsub_fn_Xhl,
    output logic [1:0]             logic_fn_Xhl,
    output logic [1:0]             alu_fn_type_Xhl,
    output logic                   prop_carry_Xhl,
    output logic                   carry_in_1_Xhl,
    output logic                   flag_reg_en_Xhl,
    output logic                   br_reg_en_Xhl,
    output logic                   last_uop_Xhl,
    output logic                   busy
);
    if (P_NBITS * C_N_OFF != 32) begin : g_bad_width
        $error("subword width times subword count must equal 32");
    end
    typedef enum logic [1:0] {IDLE, EXEC, TGT} state_t;
    state_t               state;
    logic [C_OFFBITS-1:0] cnt;
    logic [2:0]           op;
    logic                 use_imm;
    logic [4:0]           rs1, rs2, rd;
    logic is_sub, is_arith, is_br, is_logic, tgt, br_exec, first, last, issue, accept;
    always_comb begin
        is_sub   = op == 3'b001;
        is_arith = op == 3'b000 || is_sub;
        is_br    = op == 3'b101 || op == 3'b110;
        is_logic = !is_arith && !is_br;
        tgt      = state == TGT;
        br_exec  = is_br && state == EXEC;
        first    = cnt == '0;
        last     = cnt == C_OFFBITS'(C_N_OFF - 1);
        issue    = state != IDLE && !stall_Rhl;
        accept   = inst.inst_val && inst.inst_rdy;
    end
    // the branch operand pass never ends an instruction, so it cannot hand over
    assign inst.inst_rdy     = state == IDLE || (issue && last && !br_exec);
    assign busy              = state != IDLE;
    assign rega_addr_Rhl     = state == IDLE ? 5'd0 : rs1;
    assign regb_addr_Rhl     = state == IDLE ? 5'd0 : rs2;
    assign a_subword_off_Rhl = cnt;
    assign b_subword_off_Rhl = cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            cnt                <= '0;
            op                 <= '0;
            use_imm            <= 1'b0;
            rs1                <= '0;
            rs2                <= '0;
            rd                 <= '0;
            a_mux_sel_Xhl      <= 1'b0;
            b_mux_sel_Xhl      <= 1'b0;
            wb_en_Xhl          <= 1'b0;
            wb_addr_Xhl        <= '0;
            wb_subword_off_Xhl <= '0;
            addsub_fn_Xhl      <= 1'b0;
            logic_fn_Xhl       <= '0;
            alu_fn_type_Xhl    <= '0;
            prop_carry_Xhl     <= 1'b0;
            carry_in_1_Xhl     <= 1'b0;
            flag_reg_en_Xhl    <= 1'b0;
            br_reg_en_Xhl      <= 1'b0;
            last_uop_Xhl       <= 1'b0;
        end else begin
            if (accept) begin
                state   <= EXEC;
                cnt     <= '0;
                op      <= inst.inst_op;
                use_imm <= inst.inst_use_imm;
                rs1     <= inst.inst_rs1;
                rs2     <= inst.inst_rs2;
                rd      <= inst.inst_rd;
            end else if (issue) begin
                cnt <= cnt + 1'b1;
                if (last)
                    state <= br_exec ? TGT : IDLE;
            end
            // gated controls collapse to a bubble; datapath selectors below only move on issue
            wb_en_Xhl       <= issue && !is_br && rd != 5'd0;
            flag_reg_en_Xhl <= issue && (is_arith || br_exec);
            br_reg_en_Xhl   <= issue && br_exec && last;
            last_uop_Xhl    <= issue && last && !br_exec;
            prop_carry_Xhl  <= issue && !is_logic && !first;
            carry_in_1_Xhl  <= issue && is_sub && first;
            a_mux_sel_Xhl   <= issue && tgt;
            b_mux_sel_Xhl   <= issue && (is_br ? !tgt : !use_imm);
            if (issue) begin
                wb_addr_Xhl        <= rd;
                wb_subword_off_Xhl <= cnt;
                addsub_fn_Xhl      <= is_sub || br_exec;
                logic_fn_Xhl       <= op == 3'b011 ? 2'b01 : op == 3'b100 ? 2'b10 : 2'b00;
                alu_fn_type_Xhl    <= is_logic ? 2'b01 : 2'b00;
            end
        end
    end
endmodule

// File: tb/tb_param_simd_lane_seq.sv
// tb_param_simd_lane_seq: directed checks of micro-op sequencing, stalls, back-to-back issue and reset.
module tb_param_simd_lane_seq;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, XOR = 3'b100, BEQ = 3'b101, BNE = 3'b110;
    logic clk = 1'b0, reset = 1'b0, stall_Rhl = 1'b0;
    logic [4:0] rega_addr_Rhl, regb_addr_Rhl, wb_addr_Xhl;
    logic [2:0] a_subword_off_Rhl, b_subword_off_Rhl, wb_subword_off_Xhl;
    logic a_mux_sel_Xhl, b_mux_sel_Xhl, wb_en_Xhl, addsub_fn_Xhl;
    logic [1:0] logic_fn_Xhl, alu_fn_type_Xhl;
    logic prop_carry_Xhl, carry_in_1_Xhl, flag_reg_en_Xhl, br_reg_en_Xhl, last_uop_Xhl, busy;
    int errs = 0, checks = 0;
    always #5 clk = ~clk;
    param_simd_lane_seq_if ifc ();
    param_simd_lane_seq dut (
        .clk(clk), .reset(reset), .inst(ifc.slave), .stall_Rhl(stall_Rhl),
        .rega_addr_Rhl(rega_addr_Rhl), .regb_addr_Rhl(regb_addr_Rhl),
        .a_subword_off_Rhl(a_subword_off_Rhl), .b_subword_off_Rhl(b_subword_off_Rhl),
        .a_mux_sel_Xhl(a_mux_sel_Xhl), .b_mux_sel_Xhl(b_mux_sel_Xhl), .wb_en_Xhl(wb_en_Xhl),
        .wb_addr_Xhl(wb_addr_Xhl), .wb_subword_off_Xhl(wb_subword_off_Xhl),
        .addsub_fn_Xhl(addsub_fn_Xhl), .logic_fn_Xhl(logic_fn_Xhl), .alu_fn_type_Xhl(alu_fn_type_Xhl),
        .prop_carry_Xhl(prop_carry_Xhl), .carry_in_1_Xhl(carry_in_1_Xhl),
        .flag_reg_en_Xhl(flag_reg_en_Xhl), .br_reg_en_Xhl(br_reg_en_Xhl),
        .last_uop_Xhl(last_uop_Xhl), .busy(busy)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // presents one instruction for a single accepting edge; returns in the cycle after accept
    task automatic issue(input logic [2:0] op, input logic imm, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        chk("rdy_before_issue", ifc.inst_rdy, 1);
        ifc.inst_val = 1'b1;
        ifc.inst_op = op;
        ifc.inst_use_imm = imm;
        ifc.inst_rs1 = a;
        ifc.inst_rs2 = b;
        ifc.inst_rd = d;
        @(negedge clk);
        ifc.inst_val = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        ifc.inst_val = 1'b0; ifc.inst_op = '0; ifc.inst_use_imm = 1'b0;
        ifc.inst_rs1 = '0; ifc.inst_rs2 = '0; ifc.inst_rd = '0;
        @(negedge clk);
        chk("rst_rdy", ifc.inst_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wb_en", wb_en_Xhl, 0);
        chk("rst_last", last_uop_Xhl, 0);
        chk("rst_rega", rega_addr_Rhl, 0);
        reset = 1'b1;
        @(negedge clk);
        // ADD x3 = x1 + x2
        issue(ADD, 1'b0, 5'd1, 5'd2, 5'd3);
        for (int k = 0; k <= 9; k++) begin
            if (k < 8) begin
                chk($sformatf("add_aoff%0d", k), a_subword_off_Rhl, k);
                chk($sformatf("add_boff%0d", k), b_subword_off_Rhl, k);
                chk($sformatf("add_rega%0d", k), rega_addr_Rhl, 1);
                chk($sformatf("add_regb%0d", k), regb_addr_Rhl, 2);
            end
            if (k >= 1 && k <= 8) begin
                chk($sformatf("add_wb_en%0d", k), wb_en_Xhl, 1);
                chk($sformatf("add_prop%0d", k), prop_carry_Xhl, k != 1);
                chk($sformatf("add_last%0d", k), last_uop_Xhl, k == 8);
                chk($sformatf("add_wboff%0d", k), wb_subword_off_Xhl, k - 1);
                chk($sformatf("add_wbaddr%0d", k), wb_addr_Xhl, 3);
                chk($sformatf("add_bmux%0d", k), b_mux_sel_Xhl, 1);
                chk($sformatf("add_flag%0d", k), flag_reg_en_Xhl, 1);
            end
            if (k == 9) begin
                chk("add_done_wb_en", wb_en_Xhl, 0);
                chk("add_done_busy", busy, 0);
            end
            @(negedge clk);
        end
        // SUB with rd = 0: no writeback, carry-in only on first subword
        issue(SUB, 1'b0, 5'd4, 5'd5, 5'd0);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("sub_cin%0d", k), carry_in_1_Xhl, k == 0);
            chk($sformatf("sub_addsub%0d", k), addsub_fn_Xhl, 1);
            chk($sformatf("sub_wb_en%0d", k), wb_en_Xhl, 0);
            chk($sformatf("sub_last%0d", k), last_uop_Xhl, k == 7);
            @(negedge clk);
        end
        // BNE: compare pass then target pass
        issue(BNE, 1'b0, 5'd6, 5'd7, 5'd8);
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("bne_amux%0d", k), a_mux_sel_Xhl, k >= 8);
            chk($sformatf("bne_bmux%0d", k), b_mux_sel_Xhl, k < 8);
            chk($sformatf("bne_addsub%0d", k), addsub_fn_Xhl, k < 8);
            chk($sformatf("bne_flag%0d", k), flag_reg_en_Xhl, k < 8);
            chk($sformatf("bne_br%0d", k), br_reg_en_Xhl, k == 7);
            chk($sformatf("bne_last%0d", k), last_uop_Xhl, k == 15);
            chk($sformatf("bne_wb_en%0d", k), wb_en_Xhl, 0);
            chk($sformatf("bne_prop%0d", k), prop_carry_Xhl, k != 0 && k != 8);
            @(negedge clk);
        end
        // two XORs back to back with inst_val held high
        chk("xor_rdy0", ifc.inst_rdy, 1);
        ifc.inst_val = 1'b1; ifc.inst_op = XOR; ifc.inst_use_imm = 1'b0;
        ifc.inst_rs1 = 5'd1; ifc.inst_rs2 = 5'd2; ifc.inst_rd = 5'd9;
        @(negedge clk);
        ifc.inst_rd = 5'd10;
        for (int j = 1; j <= 18; j++) begin
            if (j <= 16)
                chk($sformatf("xor_rdy%0d", j), ifc.inst_rdy, j == 8 || j == 16);
            if (j >= 2 && j <= 17) begin
                chk($sformatf("xor_wb_en%0d", j), wb_en_Xhl, 1);
                chk($sformatf("xor_fn%0d", j), logic_fn_Xhl, 2);
                chk($sformatf("xor_type%0d", j), alu_fn_type_Xhl, 1);
                chk($sformatf("xor_wbaddr%0d", j), wb_addr_Xhl, j <= 9 ? 9 : 10);
                chk($sformatf("xor_last%0d", j), last_uop_Xhl, j == 9 || j == 17);
                chk($sformatf("xor_wboff%0d", j), wb_subword_off_Xhl, (j - 2) % 8);
            end
            if (j == 18) begin
                chk("xor_done_wb_en", wb_en_Xhl, 0);
                chk("xor_done_busy", busy, 0);
            end
            if (j == 9)
                ifc.inst_val = 1'b0;
            @(negedge clk);
        end
        // ADD with a 3-cycle stall at micro-op 4
        issue(ADD, 1'b1, 5'd1, 5'd2, 5'd3);
        for (int j = 1; j <= 12; j++) begin
            if (j <= 5)
                chk($sformatf("stl_off%0d", j), a_subword_off_Rhl, j - 1);
            if (j >= 6 && j <= 8) begin
                chk($sformatf("stl_hold_off%0d", j), a_subword_off_Rhl, 4);
                chk($sformatf("stl_bubble_wb%0d", j), wb_en_Xhl, 0);
                chk($sformatf("stl_bubble_prop%0d", j), prop_carry_Xhl, 0);
                chk($sformatf("stl_rdy%0d", j), ifc.inst_rdy, 0);
                chk($sformatf("stl_busy%0d", j), busy, 1);
            end
            if (j == 6)
                chk("stl_wboff_held", wb_subword_off_Xhl, 3);
            if (j == 4)
                chk("stl_bmux_imm", b_mux_sel_Xhl, 0);
            if (j == 9) begin
                chk("stl_resume_wboff", wb_subword_off_Xhl, 4);
                chk("stl_resume_wb_en", wb_en_Xhl, 1);
            end
            if (j == 11)
                chk("stl_last_early", last_uop_Xhl, 0);
            if (j == 12)
                chk("stl_last", last_uop_Xhl, 1);
            if (j == 5)
                stall_Rhl = 1'b1;
            if (j == 8)
                stall_Rhl = 1'b0;
            @(negedge clk);
        end
        // reset pulse at micro-op 5 of a branch
        issue(BEQ, 1'b0, 5'd1, 5'd2, 5'd5);
        for (int j = 1; j < 6; j++)
            @(negedge clk);
        chk("rst_pre_off", a_subword_off_Rhl, 5);
        chk("rst_pre_flag", flag_reg_en_Xhl, 1);
        reset = 1'b0;
        #1;
        chk("rst_mid_wb_en", wb_en_Xhl, 0);
        chk("rst_mid_flag", flag_reg_en_Xhl, 0);
        chk("rst_mid_bmux", b_mux_sel_Xhl, 0);
        chk("rst_mid_addsub", addsub_fn_Xhl, 0);
        chk("rst_mid_prop", prop_carry_Xhl, 0);
        chk("rst_mid_wbaddr", wb_addr_Xhl, 0);
        chk("rst_mid_wboff", wb_subword_off_Xhl, 0);
        chk("rst_mid_off", a_subword_off_Rhl, 0);
        chk("rst_mid_rega", rega_addr_Rhl, 0);
        chk("rst_mid_rdy", ifc.inst_rdy, 1);
        chk("rst_mid_busy", busy, 0);
        @(negedge clk);
        chk("rst_hold_last", last_uop_Xhl, 0);
        reset = 1'b1;
        @(negedge clk);
        issue(ADD, 1'b0, 5'd1, 5'd2, 5'd4);
        chk("post_rst_off", a_subword_off_Rhl, 0);
        chk("post_rst_rega", rega_addr_Rhl, 1);
        @(negedge clk);
        chk("post_rst_prop", prop_carry_Xhl, 0);
        chk("post_rst_wboff", wb_subword_off_Xhl, 0);
        chk("post_rst_wb_en", wb_en_Xhl, 1);
        chk("post_rst_last", last_uop_Xhl, 0);
        chk("post_rst_br", br_reg_en_Xhl, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/param_simd_lane_seq.md
# param_simd_lane_seq

Micro-op sequencer that sits directly upstream of the SIMD lane datapath. It accepts one decoded RV32 ALU or branch instruction per valid/ready handshake and issues one 4-bit subword micro-op per cycle. For each micro-op it drives the datapath's R-stage register-read controls and, one cycle later, the matching X-stage ALU, flag and writeback controls. A 32-bit operation completes in 8 micro-ops; a conditional branch completes in 16.

## Interface
Parameters:
- P_NBITS, 4, subword width in bits (fixed; must match the datapath).
- C_N_OFF, 8, subwords per 32-bit word.
- C_OFFBITS, 3, subword offset width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- inst_val  in  1  decoded instruction valid.
- inst_rdy  out  1  sequencer can accept an instruction this cycle.
- inst_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 BEQ, 110 BNE.
- inst_use_imm  in  1  B operand comes from the immediate path.
- inst_rs1, inst_rs2, inst_rd  in  5 each  register specifiers.
- stall_Rhl  in  1  freeze issue this cycle.
- rega_addr_Rhl, regb_addr_Rhl  out  5 each  regfile read addresses.
- a_subword_off_Rhl, b_subword_off_Rhl  out  3 each  read subword offsets.
- a_mux_sel_Xhl, b_mux_sel_Xhl  out  1 each  datapath operand selects.
- wb_en_Xhl  out  1  writeback enable.
- wb_addr_Xhl  out  5  writeback register.
- wb_subword_off_Xhl  out  3  writeback subword offset.
- addsub_fn_Xhl  out  1  ALU add/subtract select.
- logic_fn_Xhl, alu_fn_type_Xhl  out  2 each  ALU logic function and result-type select.
- prop_carry_Xhl, carry_in_1_Xhl, flag_reg_en_Xhl, br_reg_en_Xhl, last_uop_Xhl  out  1 each  flag and carry controls.
- busy  out  1  an instruction is in flight.

## Operation
State machine:
- States: IDLE, EXEC (operand pass) and TGT (branch-target pass).
- There is one 3-bit subword counter `cnt`.
- IDLE → EXEC on accept (inst_val & inst_rdy). On accept, all inst_* fields are latched and `cnt` is set to 0.
- In EXEC or TGT, each non-stalled cycle issues micro-op `cnt` and increments `cnt`, which wraps 7 → 0.
- EXEC at cnt = 7:
  - For a branch, go to TGT.
  - Otherwise, if a new instruction is accepted in the same cycle, go to EXEC; if not, go to IDLE.
- TGT at cnt = 7: same back-to-back rule as EXEC.
- inst_rdy = IDLE, or (cnt = 7, !stall_Rhl, and the state is EXEC-non-branch or TGT).

R-stage outputs (combinational from state):
- rega_addr_Rhl = rs1, regb_addr_Rhl = rs2.
- a_subword_off_Rhl = b_subword_off_Rhl = cnt.
- In IDLE, both addresses are 0.

X-stage outputs are registered copies of the per-micro-op control:
- Micro-op 0 of a pass: prop_carry = 0, and carry_in_1 = 1 only for SUB.
- Micro-ops 1–7: prop_carry = 1, carry_in_1 = 0.
- ADD and SUB:
  - alu_fn_type = 00, flag_reg_en = 1.
  - addsub_fn = 1 for SUB.
  - b_mux_sel = !use_imm, a_mux_sel = 0.
  - wb_en = (rd ≠ 0).
- AND, OR and XOR:
  - alu_fn_type = 01, logic_fn = 00 / 01 / 10 respectively.
  - prop_carry = 0, carry_in_1 = 0, flag_reg_en = 0.
  - wb_en = (rd ≠ 0).
- BEQ and BNE, EXEC pass:
  - addsub_fn = 1, b_mux_sel = 1, flag_reg_en = 1, wb_en = 0.
  - br_reg_en = 1 at micro-op 7.
- BEQ and BNE, TGT pass:
  - a_mux_sel = 1, b_mux_sel = 0, addsub_fn = 0, alu_fn_type = 00.
  - flag_reg_en = 0, wb_en = 0.
- last_uop = 1 on micro-op 7 of the final pass only. It is never set in the same micro-op as br_reg_en.
- wb_addr_Xhl = rd and wb_subword_off_Xhl = cnt of the issued micro-op.

Bubbles:
- A bubble in X is produced by IDLE, by a stalled cycle, or by reset.
- In a bubble, wb_en, flag_reg_en, br_reg_en, last_uop, prop_carry, carry_in_1, a_mux_sel and b_mux_sel are 0. All other X-stage outputs hold their previous value.

## Timing
- Accept in cycle t → micro-op 0 in R at t+1 → micro-op 0 in X at t+2.
- ALU instruction: last_uop_Xhl in cycle t+9. Branch: br_reg_en_Xhl at t+9 and last_uop_Xhl at t+17.
- Back-to-back: the next instruction's micro-op 0 appears in R the cycle after the previous micro-op 7, so there are zero bubbles.
- stall_Rhl:
  - State, `cnt` and the R-stage outputs hold.
  - The next X cycle is a bubble.
  - inst_rdy = 0, except in IDLE.
- Reset, asserted at any time including mid-instruction:
  - State returns to IDLE, `cnt` = 0, and the latched fields are cleared.
  - All X-stage outputs = 0, inst_rdy = 1, busy = 0.
  - The in-flight instruction is dropped with no partial last_uop.
- busy = (state ≠ IDLE).

## Test plan
- ADD x3 = x1 + x2, rd = 3:
  - Offsets 0..7 in R at t+1..t+8.
  - wb_en_Xhl = 1 at t+2..t+9; prop_carry_Xhl = 0,1,1,1,1,1,1,1.
  - last_uop_Xhl only at t+9.
- SUB with rd = 0:
  - carry_in_1_Xhl = 1 only at micro-op 0; addsub_fn_Xhl = 1 throughout.
  - wb_en_Xhl = 0 for all 8 micro-ops.
- BNE:
  - br_reg_en_Xhl at t+9 with last_uop_Xhl = 0.
  - TGT pass at t+10..t+17 with a_mux_sel_Xhl = 1 and b_mux_sel_Xhl = 0.
  - last_uop_Xhl at t+17.
- Two XORs with inst_val held high:
  - inst_rdy pulses on the first XOR's micro-op 7.
  - 16 consecutive non-bubble X cycles; logic_fn_Xhl = 10.
- stall_Rhl for 3 cycles at micro-op 4 of an ADD:
  - R offset holds at 4 and 3 X bubbles appear.
  - Completion slips by 3 cycles.
- Reset pulse at micro-op 5 of a branch:
  - Outputs go to 0 immediately; inst_rdy = 1.
  - The next ADD starts at offset 0 with prop_carry = 0.
